// File: rtl/wallace_mult_pipe.sv
// 3-stage pipelined Wallace-tree multiplier, unsigned or two's-complement per transaction.
// Define WTM_PERF_CNT_EN to add the txn_count / stall_count performance counters.
module wallace_mult_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               tc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result
`ifdef WTM_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   txn_count,
  output logic [CNT_W-1:0]   stall_count
`endif
);

  localparam int PW     = 2 * WIDTH;
  localparam int H      = WIDTH + 2;
  localparam int LAYERS = WIDTH;

  if (WIDTH < 4 || WIDTH > 32 || CNT_W < 1) begin : g_param_check
    $error("wallace_mult_pipe: WIDTH must be 4..32 and CNT_W at least 1");
  end

  logic               s1_v_q, s1_v_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               tc_q, tc_d;
  logic               s2_v_q, s2_v_d;
  logic [PW-1:0]      sum_q, sum_d;
  logic [PW-1:0]      carry_q, carry_d;
  logic               s3_v_q, s3_v_d;
  logic [PW-1:0]      result_q, result_d;

  logic               s1_load, s2_load, s3_load;

  // Each column is a bit stack: pushes shift in at bit 0, so unused upper bits stay 0.
  logic [H-1:0]       col_bits [PW];
  logic [H-1:0]       nxt_bits [PW];
  int                 col_n    [PW];
  int                 nxt_n    [PW];
  logic [PW-1:0]      tree_sum, tree_carry;

  // A stage may load when it is empty or its contents move on this cycle.
  always_comb begin
    s3_load  = !s3_v_q || out_ready;
    s2_load  = !s2_v_q || s3_load;
    s1_load  = !s1_v_q || s2_load;
    in_ready = s1_load;
  end

  // Partial products with Baugh-Wooley correction, then Wallace reduction to two rows.
  always_comb begin
    int           max_n;
    logic [H-1:0] rem;
    logic         pp, s, cy;
    // NOTE: every variable gets a default at the top of the block, so no path can infer a latch.
    max_n = 0;
    rem   = '0;
    pp    = 1'b0;
    s     = 1'b0;
    cy    = 1'b0;
    for (int c = 0; c < PW; c++) begin
      col_bits[c] = '0;
      col_n[c]    = 0;
      nxt_bits[c] = '0;
      nxt_n[c]    = 0;
    end
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pp = a_q[j] & b_q[i];
        if (tc_q && ((i == WIDTH - 1) != (j == WIDTH - 1))) pp = ~pp;
        col_bits[i+j] = {col_bits[i+j][H-2:0], pp};
        col_n[i+j]    = col_n[i+j] + 1;
      end
    end
    // Signed correction constants 2^WIDTH + 2^(2*WIDTH-1); zero bits in unsigned mode.
    col_bits[WIDTH] = {col_bits[WIDTH][H-2:0], tc_q};
    col_n[WIDTH]    = col_n[WIDTH] + 1;
    col_bits[PW-1]  = {col_bits[PW-1][H-2:0], tc_q};
    col_n[PW-1]     = col_n[PW-1] + 1;

    for (int l = 0; l < LAYERS; l++) begin
      max_n = 0;
      for (int c = 0; c < PW; c++) begin
        if (col_n[c] > max_n) max_n = col_n[c];
      end
      if (max_n > 2) begin
        for (int c = 0; c < PW; c++) begin
          nxt_bits[c] = '0;
          nxt_n[c]    = 0;
        end
        for (int c = 0; c < PW; c++) begin
          rem = col_bits[c];
          for (int k = 0; k < H; k += 3) begin
            if (k + 3 <= col_n[c]) begin
              s  = rem[0] ^ rem[1] ^ rem[2];
              cy = (rem[0] & rem[1]) | (rem[2] & (rem[0] ^ rem[1]));
              nxt_bits[c] = {nxt_bits[c][H-2:0], s};
              nxt_n[c]    = nxt_n[c] + 1;
              if (c + 1 < PW) begin
                nxt_bits[c+1] = {nxt_bits[c+1][H-2:0], cy};
                nxt_n[c+1]    = nxt_n[c+1] + 1;
              end
            end else if (k + 2 == col_n[c]) begin
              s  = rem[0] ^ rem[1];
              cy = rem[0] & rem[1];
              nxt_bits[c] = {nxt_bits[c][H-2:0], s};
              nxt_n[c]    = nxt_n[c] + 1;
              if (c + 1 < PW) begin
                nxt_bits[c+1] = {nxt_bits[c+1][H-2:0], cy};
                nxt_n[c+1]    = nxt_n[c+1] + 1;
              end
            end else if (k + 1 == col_n[c]) begin
              nxt_bits[c] = {nxt_bits[c][H-2:0], rem[0]};
              nxt_n[c]    = nxt_n[c] + 1;
            end
            rem = rem >> 3;
          end
        end
        col_bits = nxt_bits;
        col_n    = nxt_n;
      end
    end
    for (int c = 0; c < PW; c++) begin
      tree_sum[c]   = col_bits[c][0];
      tree_carry[c] = col_bits[c][1];
    end
  end

  always_comb begin
    s1_v_d   = s1_v_q;
    a_d      = a_q;
    b_d      = b_q;
    tc_d     = tc_q;
    s2_v_d   = s2_v_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    s3_v_d   = s3_v_q;
    result_d = result_q;
    if (s1_load) begin
      s1_v_d = in_valid;
      if (in_valid) begin
        a_d  = a;
        b_d  = b;
        tc_d = tc;
      end
    end
    if (s2_load) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        sum_d   = tree_sum;
        carry_d = tree_carry;
      end
    end
    // Data only moves with a valid token, so result holds its last product between bursts.
    if (s3_load) begin
      s3_v_d = s2_v_q;
      if (s2_v_q) result_d = sum_q + carry_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: datapath registers are reset along with the valids so result reads 0 out of reset.
    if (rst) begin
      s1_v_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      tc_q     <= 1'b0;
      s2_v_q   <= 1'b0;
      sum_q    <= '0;
      carry_q  <= '0;
      s3_v_q   <= 1'b0;
      result_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      s1_v_q   <= s1_v_d;
      a_q      <= a_d;
      b_q      <= b_d;
      tc_q     <= tc_d;
      s2_v_q   <= s2_v_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      s3_v_q   <= s3_v_d;
      result_q <= result_d;
    end
  end

  assign out_valid = s3_v_q;
  assign result    = result_q;

`ifdef WTM_PERF_CNT_EN
  logic [CNT_W-1:0] txn_count_q, txn_count_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  always_comb begin
    txn_count_d   = txn_count_q;
    stall_count_d = stall_count_q;
    if (s3_v_q && out_ready)  txn_count_d   = txn_count_q + CNT_W'(1);
    if (s3_v_q && !out_ready) stall_count_d = stall_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_count_q   <= '0;
      stall_count_q <= '0;
    end else begin
      txn_count_q   <= txn_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign txn_count   = txn_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule
